iob_ram_2p_asym_ext_mem: RTL and testbench
==========================================

# iob_ram_2p_asym_ext_mem

Responder side of the `ext_mem_*` interface that asymmetric two-port RAM wrappers drive. It holds N independent symmetric slices of `2**MINADDR_W` x `MINDATA_W`, each with a private write port and a shared read enable. A hardware init engine zero-fills every slice after reset or on request. It sits at the SoC memory boundary where the wrapper's external-memory ports terminate.

## Interface
- `N`, default 4: number of slices; must be ≥1.
- `MINDATA_W`, default 8: slice data width.
- `MINADDR_W`, default 4: slice address width; depth is `2**MINADDR_W`.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `ext_mem_w_en`, input, N: per-slice write enable.
- `ext_mem_w_data`, input, `MINDATA_W*N`: slice p data at `[p*MINDATA_W +: MINDATA_W]`.
- `ext_mem_w_addr`, input, `MINADDR_W*N`: slice p address at `[p*MINADDR_W +: MINADDR_W]`.
- `ext_mem_r_en`, input, 1: read enable, common to all slices.
- `ext_mem_r_addr`, input, `MINADDR_W*N`: per-slice read address.
- `ext_mem_r_data`, output, `MINDATA_W*N`: per-slice read data.
- `clear`, input, 1: single-cycle request to re-zero all slices.
- `init_done`, output, 1: high when the memory is accepting traffic.
- `wr_drop`, output, 1: one-cycle pulse when a write is discarded during init.

## Operation
- FSM states are `INIT` and `READY`.
- Reset (`rst_n`=0 at an edge):
  - state goes to `INIT`.
  - init counter goes to 0.
  - `ext_mem_r_data`, `init_done` and `wr_drop` go to 0.
- `INIT` state:
  - Each cycle, writes 0 at counter address in all N slices, then increments the counter.
  - When the counter reaches `2**MINADDR_W-1`, the final zero-write happens and the state moves to `READY`.
  - External writes are ignored. `wr_drop` is high the next cycle if any `ext_mem_w_en` bit was set.
  - Reads are ignored and `ext_mem_r_data` holds 0.
- `READY` state:
  - Slice p writes when `ext_mem_w_en[p]` is set.
  - When `ext_mem_r_en` is set, every slice captures its own read address.
  - `clear`=1 returns the FSM to `INIT` with counter 0; `init_done` drops the following cycle.
- `clear` during `INIT` restarts the counter at 0.
- Reset mid-`INIT` restarts the counter at 0.
- Read-during-write to the same slice and address is read-first (old data), unless the configuration macro below is defined.
- Different slices never interact.

## Timing
- Read latency is 1 cycle: `ext_mem_r_en` sampled at edge k puts data on `ext_mem_r_data` after edge k.
- Data holds until the next enabled read.
- Write latency is 1 cycle: a read issued the cycle after a write sees the new data.
- Init duration is `2**MINADDR_W` cycles. `init_done` rises at the edge after the last zero-write, which is cycle `2**MINADDR_W` after reset release.
- `wr_drop` is registered and lags the dropped write by 1 cycle.

## Configuration
- `IOB_RAM_ASYM_EXT_MEM_BYPASS_EN` defined:
  - A same-cycle write and read to the same slice and address returns the written data (write-first).
  - Bypass is compared per slice.
- Macro undefined:
  - Read-first.
  - No comparators synthesized.

## Structure
- Shared header `iob_ram_asym_pkg.vh` holds:
  - FSM state encodings `IOB_RAM_ASYM_INIT` and `IOB_RAM_ASYM_READY`.
  - Helper macros for slice slicing offsets.
- Sub-module `iob_ram_2p_slice`: one symmetric register-array slice.
  - One write port and one read port.
  - Registered read output.
  - Optional bypass.
  - Instantiated N times by a generate loop.
- The top level owns the FSM, the init counter, the write muxing (init versus external) and `wr_drop`.

## Test plan
All scenarios use N=4, MINDATA_W=8, MINADDR_W=4.
- **Reset release:** hold `rst_n`=0 for 3 cycles, then release. `init_done` must rise exactly 16 cycles later. Then read address 3 on all slices -> `ext_mem_r_data`=0x00000000 one cycle later.
- **Write then read:** in `READY`, write 0xA5 to slice 2, address 5; next cycle read address 5 on all slices -> `ext_mem_r_data`=0x00A50000.
- **Collision:** write 0x3C to slice 0, address 7, while reading address 7 in the same cycle, with the location previously holding 0x11.
  - Macro undefined -> slice 0 data = 0x11.
  - Macro defined -> 0x3C.
- **Write during init:** pulse `ext_mem_w_en`=4'b0001 at cycle 4 after reset. `wr_drop`=1 at cycle 5 only. After `init_done`, that location reads 0x00.
- **Clear:** after writing 0xFF to slice 1, address 0, assert `clear` for 1 cycle.
  - `init_done`=0 the next cycle, then 1 again 16 cycles later.
  - Slice 1, address 0 then reads 0x00.
- **Reset mid-init:** assert `rst_n`=0 at init cycle 10, release after 1 cycle. `init_done` must rise 16 cycles after the release, not earlier.

Source files
------------

// File: rtl/iob_ram_2p_asym_ext_mem_pkg.sv
// Shared types and helpers for the asymmetric-RAM external-memory responder.
package iob_ram_2p_asym_ext_mem_pkg;

  // Controller states: zero-fill in progress, or accepting traffic.
  typedef enum logic [0:0] {
    StInit  = 1'b0,
    StReady = 1'b1
  } state_e;

  // LSB offset of slice p inside a flat bus whose per-slice field is w bits wide.
  function automatic int unsigned slice_lsb(input int unsigned p, input int unsigned w);
    return p * w;
  endfunction

endpackage

// File: rtl/iob_ram_2p_asym_ext_mem_if.sv
// ext_mem_* bundle between an asymmetric RAM wrapper (master) and the responder (slave).
interface iob_ram_2p_asym_ext_mem_if #(
  parameter int unsigned N         = 4,
  parameter int unsigned MINDATA_W = 8,
  parameter int unsigned MINADDR_W = 4
);

  logic [N-1:0]           ext_mem_w_en;
  logic [MINDATA_W*N-1:0] ext_mem_w_data;
  logic [MINADDR_W*N-1:0] ext_mem_w_addr;
  logic                   ext_mem_r_en;
  logic [MINADDR_W*N-1:0] ext_mem_r_addr;
  logic [MINDATA_W*N-1:0] ext_mem_r_data;
  logic                   clear;
  logic                   init_done;
  logic                   wr_drop;

  modport master (
    output ext_mem_w_en, ext_mem_w_data, ext_mem_w_addr,
    output ext_mem_r_en, ext_mem_r_addr, clear,
    input  ext_mem_r_data, init_done, wr_drop
  );

  modport slave (
    input  ext_mem_w_en, ext_mem_w_data, ext_mem_w_addr,
    input  ext_mem_r_en, ext_mem_r_addr, clear,
    output ext_mem_r_data, init_done, wr_drop
  );

endinterface

// File: rtl/iob_ram_2p_slice.sv
// One symmetric register-array slice: one write port, one registered read port.
// IOB_RAM_ASYM_EXT_MEM_BYPASS_EN: same-address write/read in one cycle returns the
// written data (write-first); otherwise read-first with no comparator.
module iob_ram_2p_slice #(
  parameter int unsigned DataW = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [DataW-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [DataW-1:0] rd_data_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rd_word;
  logic [DataW-1:0] rd_data_q;

`ifdef IOB_RAM_ASYM_EXT_MEM_BYPASS_EN
  assign rd_word = (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];
`else
  assign rd_word = mem_q[rd_addr_i];
`endif

  // Storage array; no reset, the init engine zero-fills it.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read data; flushed to zero whenever the controller is (re)initialising.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (flush_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= rd_word;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/iob_ram_2p_asym_ext_mem.sv
// Responder for the ext_mem_* ports of asymmetric two-port RAM wrappers.
// N independent slices, zero-filled by an init engine after reset or on clear.
// Optional macro IOB_RAM_ASYM_EXT_MEM_BYPASS_EN selects write-first collisions.
module iob_ram_2p_asym_ext_mem
  import iob_ram_2p_asym_ext_mem_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned MINDATA_W = 8,
  parameter int unsigned MINADDR_W = 4
) (
  input logic                          clk,
  input logic                          rst_n,
  iob_ram_2p_asym_ext_mem_if.slave     bus
);

  state_e                 state_q, state_d;
  logic [MINADDR_W-1:0]   cnt_q, cnt_d;
  logic                   init_done_q;
  logic                   wr_drop_q;
  logic                   in_init;
  logic                   flush;
  logic [MINDATA_W*N-1:0] r_data;

  assign in_init = (state_q == StInit);
  // Read registers are zeroed on any edge that lands in INIT.
  assign flush   = (state_d == StInit);

  // Next-state and init-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        if (bus.clear) begin
          cnt_d = '0;
        end else if (&cnt_q) begin
          state_d = StReady;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReady: begin
        if (bus.clear) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == StReady);
      wr_drop_q   <= in_init & (|bus.ext_mem_w_en);
    end
  end

  for (genvar p = 0; p < N; p++) begin : g_slice
    localparam int unsigned DLsb = slice_lsb(p, MINDATA_W);
    localparam int unsigned ALsb = slice_lsb(p, MINADDR_W);

    logic                 wr_en;
    logic [MINADDR_W-1:0] wr_addr;
    logic [MINDATA_W-1:0] wr_data;
    logic                 rd_en;

    // Init engine owns the write port while zero-filling.
    assign wr_en   = in_init | bus.ext_mem_w_en[p];
    assign wr_addr = in_init ? cnt_q : bus.ext_mem_w_addr[ALsb +: MINADDR_W];
    assign wr_data = in_init ? '0 : bus.ext_mem_w_data[DLsb +: MINDATA_W];
    assign rd_en   = ~in_init & bus.ext_mem_r_en;

    iob_ram_2p_slice #(
      .DataW (MINDATA_W),
      .AddrW (MINADDR_W)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (flush),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_en_i   (rd_en),
      .rd_addr_i (bus.ext_mem_r_addr[ALsb +: MINADDR_W]),
      .rd_data_o (r_data[DLsb +: MINDATA_W])
    );
  end

  assign bus.ext_mem_r_data = r_data;
  assign bus.init_done      = init_done_q;
  assign bus.wr_drop        = wr_drop_q;

endmodule

// File: tb/tb_iob_ram_2p_asym_ext_mem.sv
// Directed bench for iob_ram_2p_asym_ext_mem (N=4, MINDATA_W=8, MINADDR_W=4).
module tb_iob_ram_2p_asym_ext_mem;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  iob_ram_2p_asym_ext_mem_if #(.N(4), .MINDATA_W(8), .MINADDR_W(4)) bus ();

  iob_ram_2p_asym_ext_mem #(
    .N         (4),
    .MINDATA_W (8),
    .MINADDR_W (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef IOB_RAM_ASYM_EXT_MEM_BYPASS_EN
  localparam logic [31:0] ExpColl = 32'h1111_113C;
`else
  localparam logic [31:0] ExpColl = 32'h1111_1111;
`endif

  typedef struct {
    logic [3:0]  w_en;
    logic [15:0] w_addr;
    logic [31:0] w_data;
    logic        r_en;
    logic [15:0] r_addr;
    logic [31:0] exp_r_data;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ext_mem_w_en   = '0;
    bus.ext_mem_w_addr = '0;
    bus.ext_mem_w_data = '0;
    bus.ext_mem_r_en   = 1'b0;
    bus.ext_mem_r_addr = '0;
    bus.clear          = 1'b0;
  endtask

  // Count 16 init edges; init_done must be high only after the 16th.
  task automatic expect_init(input string name, input logic chk_rdata);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("%s_done_c%0d", name, i), {31'd0, bus.init_done}, {31'd0, (i == 16)});
      if (chk_rdata) check($sformatf("%s_rdata_c%0d", name, i), bus.ext_mem_r_data, 32'h0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Fields: w_en, w_addr, w_data, r_en, r_addr, expected r_data after the edge.
    vecs[0]  = '{4'b0100, 16'h0500, 32'h00A5_0000, 1'b0, 16'h0000, 32'h0000_0000};
    vecs[1]  = '{4'b0000, 16'h0000, 32'h0000_0000, 1'b1, 16'h5555, 32'h00A5_0000};
    vecs[2]  = '{4'b1111, 16'h7777, 32'h1111_1111, 1'b0, 16'h0000, 32'h00A5_0000};
    vecs[3]  = '{4'b0001, 16'h0007, 32'h0000_003C, 1'b1, 16'h7777, ExpColl};
    vecs[4]  = '{4'b0000, 16'h0000, 32'h0000_0000, 1'b1, 16'h7777, 32'h1111_113C};
    vecs[5]  = '{4'b1111, 16'h3210, 32'hDDCC_BBAA, 1'b0, 16'h0000, 32'h1111_113C};
    vecs[6]  = '{4'b0000, 16'h0000, 32'h0000_0000, 1'b1, 16'h3210, 32'hDDCC_BBAA};
    vecs[7]  = '{4'b0000, 16'h0000, 32'h0000_0000, 1'b1, 16'h0123, 32'h0000_0000};
    vecs[8]  = '{4'b0010, 16'h0070, 32'h0000_EE00, 1'b0, 16'h7777, 32'h0000_0000};
    vecs[9]  = '{4'b0000, 16'h0000, 32'h0000_0000, 1'b1, 16'h7777, 32'h1111_EE3C};
    vecs[10] = '{4'b0010, 16'h0000, 32'h0000_FF00, 1'b0, 16'h0000, 32'h1111_EE3C};
    vecs[11] = '{4'b0000, 16'h0000, 32'h0000_0000, 1'b1, 16'h0000, 32'h0000_FFAA};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_rdata", bus.ext_mem_r_data, 32'h0);
    check("rst_init_done", {31'd0, bus.init_done}, 32'd0);
    check("rst_wr_drop", {31'd0, bus.wr_drop}, 32'd0);

    // Release reset; one dropped write at init cycle 4 (slice 0, address 2).
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      bus.ext_mem_w_en   = (cyc == 4) ? 4'b0001 : 4'b0000;
      bus.ext_mem_w_addr = 16'h0002;
      bus.ext_mem_w_data = 32'h0000_0077;
      tick();
      check($sformatf("rel_done_c%0d", cyc), {31'd0, bus.init_done}, {31'd0, (cyc == 16)});
      check($sformatf("rel_wr_drop_c%0d", cyc), {31'd0, bus.wr_drop}, {31'd0, (cyc == 4)});
    end
    idle_inputs();

    bus.ext_mem_r_en   = 1'b1;
    bus.ext_mem_r_addr = 16'h3333;
    tick();
    check("read_a3_zero", bus.ext_mem_r_data, 32'h0);
    bus.ext_mem_r_addr = 16'h2222;
    tick();
    check("dropped_write_zero", bus.ext_mem_r_data, 32'h0);

    for (int i = 0; i < 12; i++) begin
      bus.ext_mem_w_en   = vecs[i].w_en;
      bus.ext_mem_w_addr = vecs[i].w_addr;
      bus.ext_mem_w_data = vecs[i].w_data;
      bus.ext_mem_r_en   = vecs[i].r_en;
      bus.ext_mem_r_addr = vecs[i].r_addr;
      tick();
      check($sformatf("vec%0d", i), bus.ext_mem_r_data, vecs[i].exp_r_data);
    end
    idle_inputs();

    // Clear from READY; reads during init must stay zero.
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr_init_done_low", {31'd0, bus.init_done}, 32'd0);
    check("clr_rdata_flush", bus.ext_mem_r_data, 32'h0);
    bus.ext_mem_r_en   = 1'b1;
    bus.ext_mem_r_addr = 16'h7777;
    expect_init("clr", 1'b1);
    bus.ext_mem_r_addr = 16'h0000;
    tick();
    check("clr_a0_zero", bus.ext_mem_r_data, 32'h0);
    bus.ext_mem_r_addr = 16'h7777;
    tick();
    check("clr_a7_zero", bus.ext_mem_r_data, 32'h0);
    idle_inputs();

    // Clear during INIT restarts the count.
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    repeat (5) tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr_in_init_low", {31'd0, bus.init_done}, 32'd0);
    expect_init("clr2", 1'b0);

    // Reset in the middle of INIT restarts the count.
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_done_low", {31'd0, bus.init_done}, 32'd0);
    expect_init("midrst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
